// File: rtl/rw_write_stage.sv
`default_nettype none
// ============================================================================
// Module      : rw_write_stage
// Description : Commit stage for the read-write task worker. Each retiring
//               task produces a lane-aligned line write, and either a child
//               task enqueue or a finish notification to the commit queue.
//               Undo-log restores write the saved object and always finish.
//               Three saturating statistics counters are readable over a
//               small config port.
// Revision    : 1.0 - initial release
// ============================================================================
module rw_write_stage #(
    parameter int RW_WIDTH      = 32,
    parameter int LINE_WIDTH    = 512,
    parameter int SLOT_WIDTH    = 8,
    parameter int TASK_WIDTH    = 128,
    parameter int OCC_WIDTH     = 8,
    parameter int FIN_LOG_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,

    // retiring task from the worker
    input  logic                    task_in_valid,
    output logic                    task_in_ready,
    input  logic                    task_in_undo,
    input  logic [SLOT_WIDTH-1:0]   task_in_slot,
    input  logic [31:0]             task_in_locale,
    input  logic                    task_in_wr_en,
    input  logic [RW_WIDTH-1:0]     task_in_wdata,
    input  logic                    task_in_child_valid,
    input  logic [TASK_WIDTH-1:0]   task_in_child,
    input  logic [OCC_WIDTH-1:0]    task_out_fifo_occ,
    input  logic                    gvt_slot_valid,
    input  logic [SLOT_WIDTH-1:0]   gvt_slot,

    // data-array write port
    output logic                    wvalid,
    input  logic                    wready,
    output logic [31:0]             waddr,
    output logic [LINE_WIDTH-1:0]   wdata,
    output logic [LINE_WIDTH/8-1:0] wstrb,

    // child-task enqueue
    output logic                    task_out_valid,
    input  logic                    task_out_ready,
    output logic [TASK_WIDTH-1:0]   task_out,
    output logic [SLOT_WIDTH-1:0]   task_out_slot,

    output logic                    unlock_locale,

    // finish notification to the CQ
    output logic                    finish_valid,
    input  logic                    finish_ready,
    output logic [SLOT_WIDTH-1:0]   finish_slot,
    output logic                    finish_is_undo,

    // config / statistics port
    input  logic                    cfg_wvalid,
    input  logic [7:0]              cfg_waddr,
    input  logic [31:0]             cfg_wdata,
    input  logic                    cfg_arvalid,
    input  logic [7:0]              cfg_araddr,
    output logic                    cfg_rvalid,
    output logic [31:0]             cfg_rdata
);

    localparam int c_WORDS      = LINE_WIDTH / RW_WIDTH;
    localparam int c_LANE_BITS  = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam int c_LANE_BYTES = RW_WIDTH / 8;
    localparam int c_BYTE_SHIFT = $clog2(c_LANE_BYTES);
    localparam int c_STRB_W     = LINE_WIDTH / 8;
    localparam int c_FIN_DEPTH  = 1 << FIN_LOG_DEPTH;

    localparam logic [7:0] c_ADDR_BASE   = 8'h10;
    localparam logic [7:0] c_ADDR_THRESH = 8'h14;
    localparam logic [7:0] c_ADDR_CNT_WR = 8'h20;
    localparam logic [7:0] c_ADDR_CNT_UN = 8'h24;
    localparam logic [7:0] c_ADDR_CNT_ST = 8'h28;
    localparam logic [7:0] c_ADDR_CLEAR  = 8'h2C;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]             r_base;
    logic [OCC_WIDTH-1:0]    r_thresh;

    logic                    r_wvalid;
    logic [31:0]             r_waddr;
    logic [LINE_WIDTH-1:0]   r_wdata;
    logic [c_STRB_W-1:0]     r_wstrb;

    logic                    r_tvalid;
    logic [TASK_WIDTH-1:0]   r_task;
    logic [SLOT_WIDTH-1:0]   r_task_slot;

    logic [SLOT_WIDTH:0]     r_fin_mem [c_FIN_DEPTH];
    logic [FIN_LOG_DEPTH:0]  r_fin_wptr;
    logic [FIN_LOG_DEPTH:0]  r_fin_rptr;

    logic [31:0]             r_cnt_wr;
    logic [31:0]             r_cnt_undo;
    logic [31:0]             r_cnt_stall;

    logic                    r_cfg_rvalid;
    logic [31:0]             r_cfg_rdata;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [31:0]             w_addr;
    logic [LINE_WIDTH-1:0]   w_line_data;
    logic [c_STRB_W-1:0]     w_line_strb;
    logic                    w_wr_free;
    logic                    w_out_free;
    logic                    w_fin_empty;
    logic                    w_fin_full;
    logic                    w_thresh_ok;
    logic                    w_can_accept;
    logic                    w_accept;
    logic                    w_do_write;
    logic                    w_do_child;
    logic                    w_do_push;
    logic                    w_do_pop;
    logic                    w_stall;
    logic                    w_clear;
    logic [31:0]             w_rdata;
    logic                    w_unused_cfg;

    assign w_unused_cfg = ^cfg_wdata[31:30];

    // Byte address wraps naturally at 32 bits.
    assign w_addr = r_base + (task_in_locale << c_BYTE_SHIFT);

    generate
        if (c_WORDS > 1) begin : g_multi_lane
            logic [c_LANE_BITS-1:0] w_lane;
            assign w_lane      = task_in_locale[c_LANE_BITS-1:0];
            assign w_line_data = {{(LINE_WIDTH-RW_WIDTH){1'b0}}, task_in_wdata}
                                 << (32'(w_lane) * RW_WIDTH);
            assign w_line_strb = {{(c_STRB_W-c_LANE_BYTES){1'b0}}, {c_LANE_BYTES{1'b1}}}
                                 << (32'(w_lane) * c_LANE_BYTES);
        end else begin : g_single_lane
            assign w_line_data = task_in_wdata;
            assign w_line_strb = '1;
        end
    endgenerate

    assign w_wr_free   = ~r_wvalid | wready;
    assign w_out_free  = ~r_tvalid | task_out_ready;
    assign w_fin_empty = (r_fin_wptr == r_fin_rptr);
    assign w_fin_full  = (r_fin_wptr[FIN_LOG_DEPTH] != r_fin_rptr[FIN_LOG_DEPTH]) &&
                         (r_fin_wptr[FIN_LOG_DEPTH-1:0] == r_fin_rptr[FIN_LOG_DEPTH-1:0]);

    // A task sitting on the GVT slot must never be blocked by the threshold,
    // otherwise the system could deadlock behind a full downstream FIFO.
    assign w_thresh_ok = (task_out_fifo_occ < r_thresh) ||
                         (gvt_slot_valid && (gvt_slot == task_in_slot));

    // Resource check for the three task kinds; a full finish FIFO blocks a
    // push even when it is being popped in the same cycle.
    always_comb begin
        w_can_accept = 1'b0;
        if (task_in_undo) begin
            w_can_accept = w_wr_free & ~w_fin_full;
        end else if (task_in_child_valid) begin
            w_can_accept = w_out_free & (~task_in_wr_en | w_wr_free) & w_thresh_ok;
        end else begin
            w_can_accept = ~w_fin_full & (~task_in_wr_en | w_wr_free);
        end
    end

    // Ready is held low during reset so no output toggles until release.
    assign task_in_ready = task_in_valid & ~rst & w_can_accept;
    assign w_accept      = task_in_valid & task_in_ready;
    assign unlock_locale = w_accept;

    assign w_do_write = w_accept & (task_in_undo | task_in_wr_en);
    assign w_do_child = w_accept & ~task_in_undo & task_in_child_valid;
    assign w_do_push  = w_accept & (task_in_undo | ~task_in_child_valid);
    assign w_do_pop   = ~w_fin_empty & finish_ready;
    assign w_stall    = task_in_valid & ~task_in_ready;
    assign w_clear    = cfg_wvalid & (cfg_waddr == c_ADDR_CLEAR) & cfg_wdata[0];

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------

    // Config registers: base address and child-enqueue threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base   <= '0;
            r_thresh <= '1;
        end else if (cfg_wvalid) begin
            if (cfg_waddr == c_ADDR_BASE) begin
                r_base <= {cfg_wdata[29:0], 2'b00};
            end
            if (cfg_waddr == c_ADDR_THRESH) begin
                r_thresh <= cfg_wdata[OCC_WIDTH-1:0];
            end
        end
    end

    // Write register: loads on an accepted write, holds until wready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wvalid <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else if (w_do_write) begin
            r_wvalid <= 1'b1;
            r_waddr  <= w_addr;
            r_wdata  <= w_line_data;
            r_wstrb  <= w_line_strb;
        end else if (wready) begin
            r_wvalid <= 1'b0;
        end
    end

    // Output register for the child task, holds until task_out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tvalid    <= 1'b0;
            r_task      <= '0;
            r_task_slot <= '0;
        end else if (w_do_child) begin
            r_tvalid    <= 1'b1;
            r_task      <= task_in_child;
            r_task_slot <= task_in_slot;
        end else if (task_out_ready) begin
            r_tvalid    <= 1'b0;
        end
    end

    // Finish FIFO storage and pointers; entries are {slot, is_undo}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fin_wptr <= '0;
            r_fin_rptr <= '0;
            for (int i = 0; i < c_FIN_DEPTH; i++) begin
                r_fin_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_fin_mem[r_fin_wptr[FIN_LOG_DEPTH-1:0]] <= {task_in_slot, task_in_undo};
                r_fin_wptr <= r_fin_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_fin_rptr <= r_fin_rptr + 1'b1;
            end
        end
    end

    // Saturating statistics counters; a clear overrides any increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_wr    <= '0;
            r_cnt_undo  <= '0;
            r_cnt_stall <= '0;
        end else if (w_clear) begin
            r_cnt_wr    <= '0;
            r_cnt_undo  <= '0;
            r_cnt_stall <= '0;
        end else begin
            if (w_do_write && (r_cnt_wr != '1)) begin
                r_cnt_wr <= r_cnt_wr + 32'd1;
            end
            if (w_accept && task_in_undo && (r_cnt_undo != '1)) begin
                r_cnt_undo <= r_cnt_undo + 32'd1;
            end
            if (w_stall && (r_cnt_stall != '1)) begin
                r_cnt_stall <= r_cnt_stall + 32'd1;
            end
        end
    end

    // Read-data select; unmapped addresses read as zero.
    always_comb begin
        w_rdata = '0;
        case (cfg_araddr)
            c_ADDR_CNT_WR: w_rdata = r_cnt_wr;
            c_ADDR_CNT_UN: w_rdata = r_cnt_undo;
            c_ADDR_CNT_ST: w_rdata = r_cnt_stall;
            default:       w_rdata = '0;
        endcase
    end

    // Read response is registered one cycle after the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_rvalid <= 1'b0;
            r_cfg_rdata  <= '0;
        end else begin
            r_cfg_rvalid <= cfg_arvalid;
            if (cfg_arvalid) begin
                r_cfg_rdata <= w_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wvalid         = r_wvalid;
    assign waddr          = r_waddr;
    assign wdata          = r_wdata;
    assign wstrb          = r_wstrb;
    assign task_out_valid = r_tvalid;
    assign task_out       = r_task;
    assign task_out_slot  = r_task_slot;
    assign finish_valid   = ~w_fin_empty;
    assign finish_slot    = r_fin_mem[r_fin_rptr[FIN_LOG_DEPTH-1:0]][SLOT_WIDTH:1];
    assign finish_is_undo = r_fin_mem[r_fin_rptr[FIN_LOG_DEPTH-1:0]][0];
    assign cfg_rvalid     = r_cfg_rvalid;
    assign cfg_rdata      = r_cfg_rdata;

endmodule
`default_nettype wire

// File: tb/tb_rw_write_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_rw_write_stage
// Description : Self-checking bench for rw_write_stage. A queue-based model
//               of the three downstream resources predicts acceptance and
//               the payload at the head of each output every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rw_write_stage;

    localparam int c_FIN_DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           task_in_valid, task_in_ready, task_in_undo;
    logic [7:0]     task_in_slot;
    logic [31:0]    task_in_locale;
    logic           task_in_wr_en;
    logic [31:0]    task_in_wdata;
    logic           task_in_child_valid;
    logic [127:0]   task_in_child;
    logic [7:0]     task_out_fifo_occ;
    logic           gvt_slot_valid;
    logic [7:0]     gvt_slot;
    logic           wvalid, wready;
    logic [31:0]    waddr;
    logic [511:0]   wdata;
    logic [63:0]    wstrb;
    logic           task_out_valid, task_out_ready;
    logic [127:0]   task_out;
    logic [7:0]     task_out_slot;
    logic           unlock_locale;
    logic           finish_valid, finish_ready;
    logic [7:0]     finish_slot;
    logic           finish_is_undo;
    logic           cfg_wvalid;
    logic [7:0]     cfg_waddr;
    logic [31:0]    cfg_wdata;
    logic           cfg_arvalid;
    logic [7:0]     cfg_araddr;
    logic           cfg_rvalid;
    logic [31:0]    cfg_rdata;

    rw_write_stage u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .task_in_valid       (task_in_valid),
        .task_in_ready       (task_in_ready),
        .task_in_undo        (task_in_undo),
        .task_in_slot        (task_in_slot),
        .task_in_locale      (task_in_locale),
        .task_in_wr_en       (task_in_wr_en),
        .task_in_wdata       (task_in_wdata),
        .task_in_child_valid (task_in_child_valid),
        .task_in_child       (task_in_child),
        .task_out_fifo_occ   (task_out_fifo_occ),
        .gvt_slot_valid      (gvt_slot_valid),
        .gvt_slot            (gvt_slot),
        .wvalid              (wvalid),
        .wready              (wready),
        .waddr               (waddr),
        .wdata               (wdata),
        .wstrb               (wstrb),
        .task_out_valid      (task_out_valid),
        .task_out_ready      (task_out_ready),
        .task_out            (task_out),
        .task_out_slot       (task_out_slot),
        .unlock_locale       (unlock_locale),
        .finish_valid        (finish_valid),
        .finish_ready        (finish_ready),
        .finish_slot         (finish_slot),
        .finish_is_undo      (finish_is_undo),
        .cfg_wvalid          (cfg_wvalid),
        .cfg_waddr           (cfg_waddr),
        .cfg_wdata           (cfg_wdata),
        .cfg_arvalid         (cfg_arvalid),
        .cfg_araddr          (cfg_araddr),
        .cfg_rvalid          (cfg_rvalid),
        .cfg_rdata           (cfg_rdata)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct { logic [31:0] addr; logic [511:0] data; logic [63:0] strb; } wr_t;
    typedef struct { logic [127:0] tsk; logic [7:0] slot; } ch_t;
    typedef struct { logic [7:0] slot; logic undo; } fin_t;

    wr_t         wq[$];
    ch_t         cq[$];
    fin_t        fq[$];
    logic [31:0] m_base;
    logic [7:0]  m_thresh;
    logic [31:0] m_cnt_wr, m_cnt_undo, m_cnt_stall;
    bit          pend_rd;
    logic [31:0] pend_val;
    bit          last_acc;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [511:0] mk_line(input logic [31:0] loc, input logic [31:0] d);
        logic [511:0] l;
        int lane;
        l = '0;
        lane = int'(loc % 32'd16);
        l[lane*32 +: 32] = d;
        return l;
    endfunction

    function automatic logic [63:0] mk_strb(input logic [31:0] loc);
        logic [63:0] s;
        int lane;
        s = '0;
        lane = int'(loc % 32'd16);
        for (int b = 0; b < 4; b++) s[lane*4 + b] = 1'b1;
        return s;
    endfunction

    task automatic model_reset();
        wq.delete();
        cq.delete();
        fq.delete();
        m_base      = 32'h0;
        m_thresh    = 8'hFF;
        m_cnt_wr    = 32'h0;
        m_cnt_undo  = 32'h0;
        m_cnt_stall = 32'h0;
        pend_rd     = 1'b0;
        pend_val    = 32'h0;
    endtask

    // One clock cycle: compare outputs against the model, then advance it.
    task automatic step();
        bit   exp_rdy, wr_free, out_free, fin_free, thr_ok;
        wr_t  w;
        ch_t  c;
        fin_t f;
        @(negedge clk);
        check_eq("cfg_rvalid", cfg_rvalid, pend_rd);
        if (pend_rd) check_eq("cfg_rdata", cfg_rdata, pend_val);
        if (cfg_arvalid) begin
            pend_rd = 1'b1;
            case (cfg_araddr)
                8'h20:   pend_val = m_cnt_wr;
                8'h24:   pend_val = m_cnt_undo;
                8'h28:   pend_val = m_cnt_stall;
                default: pend_val = 32'h0;
            endcase
        end else begin
            pend_rd = 1'b0;
        end

        wr_free  = (wq.size() == 0) || wready;
        out_free = (cq.size() == 0) || task_out_ready;
        fin_free = fq.size() < c_FIN_DEPTH;
        thr_ok   = (task_out_fifo_occ < m_thresh) ||
                   (gvt_slot_valid && (gvt_slot == task_in_slot));
        if (!task_in_valid)            exp_rdy = 1'b0;
        else if (task_in_undo)         exp_rdy = wr_free && fin_free;
        else if (task_in_child_valid)  exp_rdy = out_free && (!task_in_wr_en || wr_free) && thr_ok;
        else                           exp_rdy = fin_free && (!task_in_wr_en || wr_free);

        check_eq("ready",  task_in_ready, exp_rdy);
        check_eq("unlock", unlock_locale, exp_rdy);
        check_eq("wvalid", wvalid, wq.size() != 0);
        if (wq.size() != 0) begin
            check_eq("waddr", waddr, wq[0].addr);
            check_eq("wdata", wdata, wq[0].data);
            check_eq("wstrb", wstrb, wq[0].strb);
        end
        check_eq("tvalid", task_out_valid, cq.size() != 0);
        if (cq.size() != 0) begin
            check_eq("task_out",  task_out, cq[0].tsk);
            check_eq("task_slot", task_out_slot, cq[0].slot);
        end
        check_eq("fvalid", finish_valid, fq.size() != 0);
        if (fq.size() != 0) begin
            check_eq("fin_slot", finish_slot, fq[0].slot);
            check_eq("fin_undo", finish_is_undo, fq[0].undo);
        end

        if (wq.size() != 0 && wready)         w = wq.pop_front();
        if (cq.size() != 0 && task_out_ready) c = cq.pop_front();
        if (fq.size() != 0 && finish_ready)   f = fq.pop_front();

        last_acc = exp_rdy;
        if (exp_rdy) begin
            if (task_in_undo || task_in_wr_en) begin
                w.addr = m_base + task_in_locale * 32'd4;
                w.data = mk_line(task_in_locale, task_in_wdata);
                w.strb = mk_strb(task_in_locale);
                wq.push_back(w);
                m_cnt_wr = sat_inc(m_cnt_wr);
            end
            if (task_in_undo) begin
                f.slot = task_in_slot;
                f.undo = 1'b1;
                fq.push_back(f);
                m_cnt_undo = sat_inc(m_cnt_undo);
            end else if (task_in_child_valid) begin
                c.tsk  = task_in_child;
                c.slot = task_in_slot;
                cq.push_back(c);
            end else begin
                f.slot = task_in_slot;
                f.undo = 1'b0;
                fq.push_back(f);
            end
        end
        if (task_in_valid && !exp_rdy) m_cnt_stall = sat_inc(m_cnt_stall);
        if (cfg_wvalid) begin
            if (cfg_waddr == 8'h10) m_base   = {cfg_wdata[29:0], 2'b00};
            if (cfg_waddr == 8'h14) m_thresh = cfg_wdata[7:0];
            if (cfg_waddr == 8'h2C && cfg_wdata[0]) begin
                m_cnt_wr    = 32'h0;
                m_cnt_undo  = 32'h0;
                m_cnt_stall = 32'h0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_task(input bit v, input bit undo, input bit child, input bit wen,
                            input logic [7:0] slot, input logic [31:0] loc, input logic [31:0] d);
        task_in_valid       = v;
        task_in_undo        = undo;
        task_in_child_valid = child;
        task_in_wr_en       = wen;
        task_in_slot        = slot;
        task_in_locale      = loc;
        task_in_wdata       = d;
        task_in_child       = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        cfg_wvalid = 1'b1;
        cfg_waddr  = a;
        cfg_wdata  = d;
        step();
        cfg_wvalid = 1'b0;
    endtask

    task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
        cfg_arvalid = 1'b1;
        cfg_araddr  = a;
        step();
        cfg_arvalid = 1'b0;
        d = cfg_rdata;
    endtask

    task automatic drain(input int n);
        task_in_valid  = 1'b0;
        wready         = 1'b1;
        task_out_ready = 1'b1;
        finish_ready   = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]  rd;
        logic [511:0] line;

        rst = 1'b1;
        set_task(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0);
        task_out_fifo_occ = 8'h0;
        gvt_slot_valid    = 1'b0;
        gvt_slot          = 8'h0;
        wready            = 1'b1;
        task_out_ready    = 1'b1;
        finish_ready      = 1'b1;
        cfg_wvalid        = 1'b0;
        cfg_waddr         = 8'h0;
        cfg_wdata         = 32'h0;
        cfg_arvalid       = 1'b0;
        cfg_araddr        = 8'h0;
        model_reset();

        // Reset state
        #1;
        check_eq("rst_wvalid", wvalid, 1'b0);
        check_eq("rst_tvalid", task_out_valid, 1'b0);
        check_eq("rst_fvalid", finish_valid, 1'b0);
        check_eq("rst_rvalid", cfg_rvalid, 1'b0);
        check_eq("rst_unlock", unlock_locale, 1'b0);
        check_eq("rst_waddr",  waddr, 32'h0);
        check_eq("rst_wdata",  wdata, 512'h0);
        check_eq("rst_wstrb",  wstrb, 64'h0);
        check_eq("rst_fslot",  finish_slot, 8'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word placement
        cfg_write(8'h10, 32'h0000_0400);
        set_task(1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 32'h13, 32'hDEAD_BEEF);
        step();
        task_in_valid = 1'b0;
        line = '0;
        line[127:96] = 32'hDEAD_BEEF;
        check_eq("place_waddr", waddr, 32'h104C);
        check_eq("place_wdata", wdata, line);
        check_eq("place_wstrb", wstrb, 64'h0000_F000);
        check_eq("place_fvalid", finish_valid, 1'b1);
        check_eq("place_fslot", finish_slot, 8'h03);
        check_eq("place_fundo", finish_is_undo, 1'b0);
        step();

        // Undo restore held by wready=0 for three cycles
        wready = 1'b0;
        set_task(1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 32'h7, $urandom());
        step();
        task_in_valid = 1'b0;
        check_eq("undo_fslot", finish_slot, 8'h05);
        check_eq("undo_fundo", finish_is_undo, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_eq("undo_hold_v", wvalid, 1'b1);
            check_eq("undo_hold_a", waddr, 32'h101C);
            step();
        end
        wready = 1'b1;
        step();
        check_eq("undo_done", wvalid, 1'b0);
        cfg_read(8'h24, rd);
        check_eq("undo_cnt", rd, 32'd1);

        // Threshold and GVT bypass
        cfg_write(8'h14, 32'd4);
        task_out_fifo_occ = 8'd4;
        set_task(1'b1, 1'b0, 1'b1, 1'b0, 8'h07, 32'h20, 32'h0);
        #1;
        check_eq("thr_block", task_in_ready, 1'b0);
        step();
        gvt_slot_valid = 1'b1;
        gvt_slot       = 8'h07;
        #1;
        check_eq("thr_gvt", task_in_ready, 1'b1);
        step();
        task_in_valid  = 1'b0;
        gvt_slot_valid = 1'b0;
        check_eq("thr_tvalid", task_out_valid, 1'b1);
        check_eq("thr_tslot", task_out_slot, 8'h07);
        set_task(1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 32'h21, 32'h0);
        #1;
        check_eq("thr_nochild", task_in_ready, 1'b1);
        step();
        drain(2);

        // Finish FIFO full
        cfg_write(8'h2C, 32'd1);
        finish_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            set_task(1'b1, 1'b0, 1'b0, 1'b0, 8'(10 + s), 32'(s), 32'h0);
            step();
            check_eq("full_acc", last_acc, 1'b1);
        end
        set_task(1'b1, 1'b0, 1'b0, 1'b0, 8'd14, 32'h4, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("full_stall", last_acc, 1'b0);
        end
        finish_ready = 1'b1;
        step();
        check_eq("full_poppush", last_acc, 1'b0);
        step();
        check_eq("full_resume", last_acc, 1'b1);
        task_in_valid = 1'b0;
        cfg_read(8'h28, rd);
        check_eq("stall_cnt", rd, 32'd4);
        drain(6);

        // Backpressure across both registers
        task_out_fifo_occ = 8'd0;
        wready            = 1'b0;
        task_out_ready    = 1'b0;
        set_task(1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 32'h31, $urandom());
        step();
        check_eq("bp_first", last_acc, 1'b1);
        set_task(1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 32'h32, $urandom());
        repeat (2) begin
            step();
            check_eq("bp_both", last_acc, 1'b0);
        end
        task_out_ready = 1'b1;
        step();
        check_eq("bp_wr_only", last_acc, 1'b0);
        wready = 1'b1;
        step();
        check_eq("bp_free", last_acc, 1'b1);
        drain(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            task_in_valid       = ($urandom_range(0, 9) < 7);
            task_in_undo        = ($urandom_range(0, 4) == 0);
            task_in_child_valid = 1'($urandom_range(0, 1));
            task_in_wr_en       = ($urandom_range(0, 9) < 6);
            task_in_slot        = 8'($urandom_range(0, 15));
            task_in_locale      = $urandom();
            task_in_wdata       = $urandom();
            task_in_child       = {$urandom(), $urandom(), $urandom(), $urandom()};
            task_out_fifo_occ   = 8'($urandom_range(0, 7));
            gvt_slot_valid      = 1'($urandom_range(0, 1));
            gvt_slot            = 8'($urandom_range(0, 15));
            wready              = ($urandom_range(0, 9) < 6);
            task_out_ready      = ($urandom_range(0, 9) < 6);
            finish_ready        = ($urandom_range(0, 9) < 6);
            cfg_arvalid         = ($urandom_range(0, 9) == 0);
            cfg_araddr          = 8'(32'h20 + 4 * $urandom_range(0, 4));
            step();
        end
        cfg_arvalid = 1'b0;
        gvt_slot_valid = 1'b0;
        drain(8);
        cfg_read(8'h20, rd);
        cfg_read(8'h24, rd);
        cfg_read(8'h28, rd);
        cfg_read(8'h30, rd);
        check_eq("rd_unmapped", rd, 32'h0);
        drain(1);

        // Reset mid-stream
        cfg_write(8'h10, 32'h0000_0055);
        cfg_write(8'h14, 32'd2);
        wready         = 1'b0;
        task_out_ready = 1'b0;
        finish_ready   = 1'b0;
        set_task(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 32'h40, $urandom());
        step();
        set_task(1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 32'h41, $urandom());
        step();
        check_eq("mid_wvalid", wvalid, 1'b1);
        check_eq("mid_fvalid", finish_valid, 1'b1);
        set_task(1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 32'h42, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mrst_wvalid", wvalid, 1'b0);
        check_eq("mrst_fvalid", finish_valid, 1'b0);
        check_eq("mrst_tvalid", task_out_valid, 1'b0);
        check_eq("mrst_ready",  task_in_ready, 1'b0);
        check_eq("mrst_unlock", unlock_locale, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        task_in_valid  = 1'b0;
        rst            = 1'b0;
        wready         = 1'b1;
        task_out_ready = 1'b1;
        finish_ready   = 1'b1;
        @(posedge clk);
        #1;
        set_task(1'b1, 1'b0, 1'b0, 1'b1, 8'h09, 32'h5, $urandom());
        step();
        task_in_valid = 1'b0;
        check_eq("rst_base_def", waddr, 32'd20);
        task_out_fifo_occ = 8'hFE;
        set_task(1'b1, 1'b0, 1'b1, 1'b0, 8'h0A, 32'h6, 32'h0);
        #1;
        check_eq("rst_thr_def", task_in_ready, 1'b1);
        step();
        drain(4);
        cfg_read(8'h20, rd);
        check_eq("rst_cnt_wr", rd, 32'd1);
        drain(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rw_write_stage.md
# rw_write_stage

Parametrised commit stage between the read-write task worker and the tile's data-array write port / commit queue. It accepts one retiring task per handshake and performs three actions for it:
- a lane-aligned data write;
- an optional child-task enqueue, or a finish notification to the CQ;
- an undo-log restore write.

Word width, line width, finish-FIFO depth and slot width are parameters. It adds child-only backpressure, deterministic write data and readable statistics counters.

## Interface
- RW_WIDTH, 32: object width in bits; power of 2, 8..LINE_WIDTH.
- LINE_WIDTH, 512: write-port line width in bits.
- SLOT_WIDTH, 8: CQ slot index width.
- TASK_WIDTH, 128: packed child-task width.
- OCC_WIDTH, 8: downstream task-FIFO occupancy width.
- FIN_LOG_DEPTH, 2: log2 of the finish-FIFO depth.
- clk  in  1  clock; every register updates on its rising edge.
- rst  in  1  reset; asynchronous and active-high.
- task_in_valid / task_in_ready  in/out  1  retire handshake.
- task_in_undo  in  1  task is an undo-log restore.
- task_in_slot  in  SLOT_WIDTH  CQ slot of the task.
- task_in_locale  in  32  word index.
- task_in_wr_en  in  1  a normal task writes data.
- task_in_wdata  in  RW_WIDTH  write data (object for an undo restore).
- task_in_child_valid / task_in_child  in  1 / TASK_WIDTH  child task produced.
- task_out_fifo_occ  in  OCC_WIDTH  downstream task-FIFO occupancy.
- gvt_slot_valid / gvt_slot  in  1 / SLOT_WIDTH  slot currently holding GVT.
- wvalid / wready  out/in  1  write-port handshake.
- waddr  out  32  byte address.
- wdata  out  LINE_WIDTH  line-positioned data.
- wstrb  out  LINE_WIDTH/8  byte strobes.
- task_out_valid / task_out_ready  out/in  1  child-task handshake.
- task_out  out  TASK_WIDTH  child task.
- task_out_slot  out  SLOT_WIDTH  parent slot.
- unlock_locale  out  1  locale release pulse.
- finish_valid / finish_ready  out/in  1  finish handshake.
- finish_slot  out  SLOT_WIDTH  finished slot.
- finish_is_undo  out  1  the finish entry came from an undo restore.
- cfg_wvalid, cfg_waddr[7:0], cfg_wdata[31:0]  in  register write.
- cfg_arvalid, cfg_araddr[7:0]  in  register read request.
- cfg_rvalid, cfg_rdata[31:0]  out  register read response.

## Operation
Derived values:
- WORDS = LINE_WIDTH/RW_WIDTH; lane = task_in_locale[log2(WORDS)-1:0].
- Address: waddr = base + task_in_locale*(RW_WIDTH/8), modulo 2^32.
- Data: wdata = task_in_wdata placed at bits lane*RW_WIDTH; all other bits are 0.
- Strobes: the RW_WIDTH/8 strobe bits of the selected lane are set; all others are 0.

Resources:
- Write register: one entry, free = !wvalid | wready.
- Output register: one entry, free = !task_out_valid | task_out_ready.
- Finish FIFO: 2^FIN_LOG_DEPTH entries, free = !full.

Acceptance (task_in_ready), by case:
- undo: write register free AND FIFO free. The task writes and pushes {slot, 1} to the finish FIFO.
- normal, child_valid=1: output register free AND (wr_en=0 OR write register free) AND (occ < thresh OR (gvt_slot_valid AND gvt_slot==slot)). The task loads the output register; no finish entry is pushed.
- normal, child_valid=0: FIFO free AND (wr_en=0 OR write register free). The threshold does not apply. The task pushes {slot, 0}.

Output behaviour:
- unlock_locale = task_in_valid & task_in_ready (combinational).
- task_in_ready=0 whenever task_in_valid=0.
- Registered outputs hold their values until the consumer accepts them.
- The finish FIFO supports push and pop in the same cycle. When it is full, push is blocked even if a pop occurs that cycle.

Config registers (write):
- 0x10 base <= {cfg_wdata[29:0], 2'b00}.
- 0x14 thresh <= cfg_wdata[OCC_WIDTH-1:0].
- Other addresses are ignored.

Counters (read, 32-bit, saturating at 0xFFFFFFFF):
- 0x20 writes issued.
- 0x24 undo restores.
- 0x28 cycles with task_in_valid=1 and task_in_ready=0.
- Writing 1 to 0x2C clears all three counters.
- cfg_rvalid is registered one cycle after cfg_arvalid. Reads of any other address return 0.

## Timing
- Reset values: base=0, thresh=all-ones, counters=0, FIFO empty. wvalid, task_out_valid, finish_valid, cfg_rvalid and unlock_locale are 0. Data outputs are 0.
- Latency from acceptance at cycle T:
  - wvalid=1 at T+1;
  - task_out_valid=1 at T+1;
  - finish_valid=1 at T+1 if the FIFO was empty.
- Full-rate throughput: one task per cycle when all consumers are always ready.
- Simultaneous events:
  - A config write to thresh takes effect from the next cycle.
  - A counter clear in the same cycle as an increment results in 0.
- Reset mid-operation drops every pending write, task and finish entry. No output toggles until rst deasserts.

## Test plan
- Word placement: RW_WIDTH=32, base=0x1000, normal task with locale=0x13, wdata=0xDEADBEEF, no child -> waddr=0x104C; wdata[127:96]=0xDEADBEEF, other bits 0; wstrb=0x0000_F000; finish_slot equal to the task slot with finish_is_undo=0 at T+1.
- Undo restore: task with undo=1, slot=5, while wready=0 for 3 cycles -> wvalid held for 3 cycles with a stable payload; finish entry {5, 1}; counter 0x24=1.
- Threshold and GVT bypass: thresh=4, occ=4, child task in slot 7 -> ready=0. Then gvt_slot=7 with gvt_slot_valid=1 -> accepted, task_out_slot=7. Separately, a task with no child under the same occ -> accepted.
- FIFO full: FIN_LOG_DEPTH=2, finish_ready=0, 5 no-child tasks -> 4 accepted; 5th stalls until finish_ready=1; stall counter 0x28 counts the stalled cycles.
- Backpressure across both registers: task_out_ready=0 and wready=0 with a back-to-back child+write task stream -> second task not accepted until both registers are freed; no data loss.
- Reset mid-stream: assert rst while wvalid=1 and the FIFO holds 2 entries -> all valids drop immediately; base and thresh return to defaults.
